// File: rtl/rf_wb_queue_if.sv
// rtl/rf_wb_queue_if.sv - execution-lane and register-file write port bundle for rf_wb_queue
interface rf_wb_queue_if #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             i_flush;
    logic [3:0]       i_valid;
    logic [WIDTH-1:0] i_addr0, i_addr1, i_addr2, i_addr3;
    logic [31:0]      i_data0, i_data1, i_data2, i_data3;
    logic             o_ready;
    logic             o_we0, o_we1, o_we2, o_we3;
    logic [WIDTH-1:0] o_waddr0, o_waddr1, o_waddr2, o_waddr3;
    logic [31:0]      o_wdata0, o_wdata1, o_wdata2, o_wdata3;
    logic [CW-1:0]    o_count;
    logic             o_empty;

    modport slave (
        input  i_flush, i_valid,
        input  i_addr0, i_addr1, i_addr2, i_addr3,
        input  i_data0, i_data1, i_data2, i_data3,
        output o_ready, o_count, o_empty,
        output o_we0, o_we1, o_we2, o_we3,
        output o_waddr0, o_waddr1, o_waddr2, o_waddr3,
        output o_wdata0, o_wdata1, o_wdata2, o_wdata3
    );

    modport master (
        output i_flush, i_valid,
        output i_addr0, i_addr1, i_addr2, i_addr3,
        output i_data0, i_data1, i_data2, i_data3,
        input  o_ready, o_count, o_empty,
        input  o_we0, o_we1, o_we2, o_we3,
        input  o_waddr0, o_waddr1, o_waddr2, o_waddr3,
        input  o_wdata0, o_wdata1, o_wdata2, o_wdata3
    );
endinterface

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - 4-in/4-out in-order write-back queue feeding the integer register file
module rf_wb_queue #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rf_wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 4);

    logic [WIDTH-1:0] mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       we_q, we_d;
    logic [WIDTH-1:0] waddr_q [4];
    logic [WIDTH-1:0] waddr_d [4];
    logic [31:0]      wdata_q [4];
    logic [31:0]      wdata_d [4];

    logic [WIDTH-1:0] lane_addr [4];
    logic [31:0]      lane_data [4];
    logic [3:0]       elig;
    logic [2:0]       off [4];
    logic [2:0]       enq_cnt;
    logic [2:0]       enq_n;
    logic [2:0]       drain_n;
    logic [PW-1:0]    wr_idx [4];
    logic [PW-1:0]    rd_idx [4];
    logic             ready;
    logic             accept;

    assign lane_addr[0] = bus.i_addr0;
    assign lane_addr[1] = bus.i_addr1;
    assign lane_addr[2] = bus.i_addr2;
    assign lane_addr[3] = bus.i_addr3;
    assign lane_data[0] = bus.i_data0;
    assign lane_data[1] = bus.i_data1;
    assign lane_data[2] = bus.i_data2;
    assign lane_data[3] = bus.i_data3;

    // Ready looks only at registered occupancy so producers never see a path through the drain logic.
    assign ready  = (count_q <= READY_MAX);
    assign accept = ready && !bus.i_flush;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            elig[k] = bus.i_valid[k] && (lane_addr[k] != '0);
        end
    end

    // Compaction: each eligible lane lands at tail plus the number of eligible lanes below it.
    assign off[0]  = 3'd0;
    assign off[1]  = {2'b00, elig[0]};
    assign off[2]  = {2'b00, elig[0]} + {2'b00, elig[1]};
    assign off[3]  = {2'b00, elig[0]} + {2'b00, elig[1]} + {2'b00, elig[2]};
    assign enq_cnt = {2'b00, elig[0]} + {2'b00, elig[1]} + {2'b00, elig[2]} + {2'b00, elig[3]};
    assign enq_n   = accept ? enq_cnt : 3'd0;

    assign drain_n = (count_q >= CW'(4)) ? 3'd4 : count_q[2:0];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_idx[k] = tail_q + PW'(off[k]);
            rd_idx[k] = head_q + PW'(k);
        end
    end

    always_comb begin
        head_d  = head_q + PW'(drain_n);
        tail_d  = tail_q + PW'(enq_n);
        count_d = count_q - CW'(drain_n) + CW'(enq_n);
        for (int j = 0; j < 4; j++) begin
            we_d[j]    = (3'(j) < drain_n);
            waddr_d[j] = mem_addr[rd_idx[j]];
            wdata_d[j] = mem_data[rd_idx[j]];
        end
        if (bus.i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            we_d    = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= '0;
            for (int j = 0; j < 4; j++) begin
                waddr_q[j] <= '0;
                wdata_q[j] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            for (int j = 0; j < 4; j++) begin
                waddr_q[j] <= waddr_d[j];
                wdata_q[j] <= wdata_d[j];
            end
        end
    end

    // Entry storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < 4; k++) begin
                if (elig[k]) begin
                    mem_addr[wr_idx[k]] <= lane_addr[k];
                    mem_data[wr_idx[k]] <= lane_data[k];
                end
            end
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_count  = count_q;
    assign bus.o_empty  = (count_q == '0);
    assign bus.o_we0    = we_q[0];
    assign bus.o_we1    = we_q[1];
    assign bus.o_we2    = we_q[2];
    assign bus.o_we3    = we_q[3];
    assign bus.o_waddr0 = waddr_q[0];
    assign bus.o_waddr1 = waddr_q[1];
    assign bus.o_waddr2 = waddr_q[2];
    assign bus.o_waddr3 = waddr_q[3];
    assign bus.o_wdata0 = wdata_q[0];
    assign bus.o_wdata1 = wdata_q[1];
    assign bus.o_wdata2 = wdata_q[2];
    assign bus.o_wdata3 = wdata_q[3];
endmodule
